// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the execute-stage iterative divider.
package div_ctrl_pkg;

   // Default operand width; the restoring divider runs one iteration per bit.
   localparam int unsigned DIV_ITER = 32;

   // Quotient written on divide-by-zero (all ones at any width).
   localparam logic [DIV_ITER-1:0] DIV0_QUO = '1;

   // Sequencer states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_t;

endpackage : div_ctrl_pkg

// File: rtl/div_ctrl_step.sv
// One radix-2 restoring division iteration on the packed {rem, quo} vector.
module div_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [2*WIDTH:0] i_rq,
   input  logic [WIDTH-1:0] i_div,
   output logic [2*WIDTH:0] o_rq
);

   logic [2*WIDTH:0] w_shift;
   logic [WIDTH:0]   w_diff;

   // Shift left, trial-subtract the divisor from the upper WIDTH+1 bits and
   // restore (keep the shifted value) when the difference goes negative.
   always_comb begin
      w_shift = {i_rq[2*WIDTH-1:0], 1'b0};
      w_diff  = w_shift[2*WIDTH:WIDTH] - {1'b0, i_div};
      o_rq    = w_shift;
      if (!w_diff[WIDTH]) begin
         o_rq = {w_diff, w_shift[WIDTH-1:1], 1'b1};
      end
   end

endmodule : div_step

// File: rtl/div_ctrl.sv
// Sequencer for the E-stage iterative divider (DIV/DIVU). Drives the
// E-stage stall and presents quotient/remainder on lo/hi.
module div_ctrl
   import div_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_ITER
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             stall_o,
   output logic             ready,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned     CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   div_state_t       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [2*WIDTH:0] r_rq;
   logic [WIDTH-1:0] r_div;
   logic             r_neg_q;
   logic             r_neg_r;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic             r_ready;

   logic             w_a_neg;
   logic             w_b_neg;
   logic             w_b_zero;
   logic [WIDTH-1:0] w_abs_a;
   logic [WIDTH-1:0] w_abs_b;
   logic [2*WIDTH:0] w_rq_next;
   logic [WIDTH-1:0] w_quo;
   logic [WIDTH-1:0] w_rem;
   logic [WIDTH-1:0] w_quo_fix;
   logic [WIDTH-1:0] w_rem_fix;

   // Operand magnitudes and sign flags; only DIV treats operands as signed.
   always_comb begin
      w_a_neg  = signed_div & a[WIDTH-1];
      w_b_neg  = signed_div & b[WIDTH-1];
      w_b_zero = (b == '0);
      w_abs_a  = w_a_neg ? (~a + WIDTH'(1)) : a;
      w_abs_b  = w_b_neg ? (~b + WIDTH'(1)) : b;
   end

   div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .i_rq  (r_rq),
      .i_div (r_div),
      .o_rq  (w_rq_next)
   );

   // Sign correction of the final iteration's quotient and remainder.
   // The remainder of a WIDTH-bit division always fits in WIDTH bits, so
   // bit 2*WIDTH of the step output is not part of the result.
   always_comb begin
      w_quo     = w_rq_next[WIDTH-1:0];
      w_rem     = w_rq_next[2*WIDTH-1:WIDTH];
      w_quo_fix = r_neg_q ? (~w_quo + WIDTH'(1)) : w_quo;
      w_rem_fix = r_neg_r ? (~w_rem + WIDTH'(1)) : w_rem;
   end

   // Stall while a divide is being accepted or running; a flush drops it.
   always_comb begin
      stall_o = ~flush & (((r_state == IDLE) & start) | (r_state == RUN));
   end

   // Sequencer: operand capture, iteration count, result write and ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_rq    <= '0;
         r_div   <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_ready <= 1'b0;
      end else begin
         r_ready <= 1'b0;
         if (flush) begin
            r_state <= IDLE;
         end else begin
            case (r_state)
               IDLE: begin
                  if (start) begin
                     if (w_b_zero) begin
                        r_lo    <= {WIDTH{DIV0_QUO[0]}};
                        r_hi    <= a;
                        r_ready <= 1'b1;
                        r_state <= DONE;
                     end else begin
                        r_rq    <= {{(WIDTH+1){1'b0}}, w_abs_a};
                        r_div   <= w_abs_b;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_cnt   <= '0;
                        r_state <= RUN;
                     end
                  end
               end
               RUN: begin
                  r_rq  <= w_rq_next;
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (r_cnt == LAST_CNT) begin
                     r_lo    <= w_quo_fix;
                     r_hi    <= w_rem_fix;
                     r_ready <= 1'b1;
                     r_state <= DONE;
                  end
               end
               DONE: begin
                  // start is still the same instruction here; never restart.
                  r_state <= IDLE;
               end
               default: begin
                  r_state <= IDLE;
               end
            endcase
         end
      end
   end

   assign ready = r_ready;
   assign hi    = r_hi;
   assign lo    = r_lo;

endmodule : div_ctrl

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: stimulus pushes expected {lo, hi}; the
// monitor pops and compares on every ready pulse.
module tb_div_ctrl;

   logic        clk;
   logic        rst;
   logic        start;
   logic        signed_div;
   logic [31:0] a;
   logic [31:0] b;
   logic        flush;
   logic        stall_o;
   logic        ready;
   logic [31:0] hi;
   logic [31:0] lo;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          last_ready_cyc = 0;
   logic [63:0] exp_q[$];
   logic [63:0] mon_e;

   div_ctrl #(.WIDTH(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .signed_div (signed_div),
      .a          (a),
      .b          (b),
      .flush      (flush),
      .stall_o    (stall_o),
      .ready      (ready),
      .hi         (hi),
      .lo         (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   // Monitor: every ready pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      if (rst === 1'b0 && ready === 1'b1) begin
         last_ready_cyc = cyc;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_ready: got ready=1 with lo=0x%08h hi=0x%08h, expected no pending result", lo, hi);
         end else begin
            mon_e = exp_q.pop_front();
            chk("lo", lo, mon_e[63:32]);
            chk("hi", hi, mon_e[31:0]);
         end
      end
   end

   // Issue one divide, count stall cycles, confirm ready in the cycle after.
   task automatic do_div(input logic [31:0] ia, input logic [31:0] ib, input logic sg,
                         input logic [31:0] elo, input logic [31:0] ehi,
                         input int exp_stall, input bit b2b);
      int n;
      n = 0;
      if (!b2b) begin
         @(posedge clk);
         #1;
      end
      a          = ia;
      b          = ib;
      signed_div = sg;
      start      = 1'b1;
      exp_q.push_back({elo, ehi});
      @(negedge clk);
      while (stall_o === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("stall_len", 32'(n), 32'(exp_stall));
      chk("ready_pulse", {31'd0, ready}, 32'd1);
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
   endtask

   initial begin
      int c1;
      logic [31:0] keep_hi;
      logic [31:0] keep_lo;
      rst = 1'b1; start = 1'b0; signed_div = 1'b0; a = '0; b = '0; flush = 1'b0;
      #12;
      chk("rst_hi", hi, 32'h0);
      chk("rst_lo", lo, 32'h0);
      chk("rst_ready", {31'd0, ready}, 32'd0);
      chk("rst_stall", {31'd0, stall_o}, 32'd0);
      @(posedge clk); #1; rst = 1'b0;

      do_div(32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          33, 0);
      do_div(32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF,   33, 0);
      do_div(32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'h0,          33, 0);
      do_div(32'h00001234,   32'd0,          1'b0, 32'hFFFFFFFF,   32'h00001234,   1,  0);
      do_div(32'd7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'd1,          33, 0);
      do_div(32'hFFFFFFF9,   32'hFFFFFFFE,   1'b1, 32'd3,          32'hFFFFFFFF,   33, 0);
      do_div(32'h80000000,   32'hFFFFFFFF,   1'b0, 32'd0,          32'h80000000,   33, 0);
      do_div(32'd5,          32'd10,         1'b0, 32'd0,          32'd5,          33, 0);
      do_div(32'hFFFFFFFF,   32'd1,          1'b0, 32'hFFFFFFFF,   32'd0,          33, 0);

      // flush together with start in IDLE: nothing accepted
      @(posedge clk); #1;
      a = 32'd50; b = 32'd5; signed_div = 1'b0; start = 1'b1; flush = 1'b1;
      @(negedge clk);
      chk("flush_start_stall", {31'd0, stall_o}, 32'd0);
      @(posedge clk); #1; start = 1'b0; flush = 1'b0;
      @(negedge clk);
      chk("flush_start_ready", {31'd0, ready}, 32'd0);

      // flush in RUN cycle 10
      keep_hi = hi; keep_lo = lo;
      @(posedge clk); #1;
      a = 32'd999; b = 32'd3; signed_div = 1'b0; start = 1'b1;
      repeat (10) @(posedge clk);
      #1; flush = 1'b1;
      @(negedge clk);
      chk("flush_run_stall", {31'd0, stall_o}, 32'd0);
      @(posedge clk); #1; flush = 1'b0; start = 1'b0;
      repeat (40) @(negedge clk);
      chk("flush_keep_hi", hi, keep_hi);
      chk("flush_keep_lo", lo, keep_lo);
      do_div(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 33, 0);

      // asynchronous reset mid-run
      @(posedge clk); #1;
      a = 32'd77; b = 32'd5; signed_div = 1'b0; start = 1'b1;
      repeat (5) @(posedge clk);
      #3; rst = 1'b1; start = 1'b0;
      #1;
      chk("arst_hi", hi, 32'h0);
      chk("arst_lo", lo, 32'h0);
      chk("arst_ready", {31'd0, ready}, 32'd0);
      chk("arst_stall", {31'd0, stall_o}, 32'd0);
      @(posedge clk); #1; rst = 1'b0;

      // back-to-back
      do_div(32'd20, 32'd3, 1'b0, 32'd6, 32'd2, 33, 0);
      c1 = last_ready_cyc;
      do_div(32'd9,  32'd4, 1'b0, 32'd2, 32'd1, 33, 1);
      chk("b2b_spacing", 32'(last_ready_cyc - c1), 32'd34);

      repeat (3) @(negedge clk);
      chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog");
   end

endmodule : tb_div_ctrl

// File: doc/div_ctrl.md
# div_ctrl

Sequencer for the execute-stage iterative divider. Accepts DIV/DIVU when the instruction sits in E, runs a radix-2 restoring division over WIDTH cycles, and drives the E-stage stall that the hazard unit consumes as `div_stallE`. Quotient and remainder are presented as `lo`/`hi` for the HI/LO write path. It supports annulment by pipeline flush and asynchronous reset mid-operation.

## Interface
- WIDTH, 32, operand width; iteration count equals WIDTH
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  DIV/DIVU instruction valid in E; held high while stalled
- signed_div  in  1  1 = DIV (signed), 0 = DIVU
- a  in  WIDTH  dividend (rs value, post-forwarding); sampled only at start
- b  in  WIDTH  divisor (rt value, post-forwarding); sampled only at start
- flush  in  1  annul current divide (exception or E-stage flush)
- stall_o  out  1  connects to div_stallE; combinational
- ready  out  1  one-cycle pulse: hi/lo valid this cycle
- hi  out  WIDTH  remainder, registered
- lo  out  WIDTH  quotient, registered

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - start & ~flush & b≠0: latch |a|, |b| (abs only if signed_div), latch sign flags, counter←0, →RUN.
  - start & ~flush & b=0: →DONE with lo←all ones, hi←a.
  - Otherwise stay in IDLE.
- RUN:
  - Each cycle performs one restoring step on the 2·WIDTH+1-bit {rem, quo} register: shift left by 1, trial-subtract the divisor from the upper WIDTH+1 bits, and set the quotient LSB when the result is non-negative.
  - counter increments each cycle. At counter = WIDTH−1 the final step is applied and sign-corrected results are written to hi/lo, then →DONE.
- DONE: ready=1, →IDLE unconditionally. Because `start` is still high this cycle (same instruction), DONE never restarts.
- Sign rules (signed_div):
  - Quotient is negated when a[MSB]≠b[MSB].
  - Remainder is negated when a[MSB]=1.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Flush: from any state, →IDLE on the next edge. hi/lo are not updated. ready is 0 that cycle.
- stall_o = ~flush & ((IDLE & start) | RUN).
- Reset: state=IDLE, counter=0, hi=0, lo=0, ready=0. stall_o=0 while start=0.
- hi/lo hold their value until the next completed divide.

## Timing
- Cycle 0 (IDLE, start): stall_o=1 combinationally, operands latched.
- Cycles 1..WIDTH (RUN): stall_o=1. The edge ending cycle WIDTH writes hi/lo.
- Cycle WIDTH+1 (DONE): stall_o=0, ready=1, hi/lo valid. The pipeline advances at the end of this cycle.
- Total stall is WIDTH+1 cycles (33 at default).
- Divide-by-zero: stall_o=1 in cycle 0 only, DONE in cycle 1.
- Back-to-back divides: the second start is seen in IDLE at cycle WIDTH+2. There is no bubble beyond DONE.
- flush and start in the same IDLE cycle: no start, stall_o=0.
- Reset asserted mid-RUN: immediate return to IDLE. Outputs take reset values without waiting for a clock edge.

## Structure
- Shared package:
  - state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - DIV_ITER = WIDTH
  - DIV0_QUO = all ones
- Counter width is $clog2(WIDTH).
- One sub-module, `div_step`: combinational single restoring iteration. Inputs are the {rem, quo} vector and the divisor. Output is the next {rem, quo} vector.
- The FSM, operand/sign registers and result registers stay in div_ctrl.

## Test plan
- Unsigned divide: DIVU a=100, b=7 → stall_o high exactly 33 cycles, then ready pulse with lo=14, hi=2.
- Signed, negative dividend: DIV a=−7 (0xFFFFFFF9), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Signed overflow case: DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide by zero: a=0x1234, b=0 → stall_o high 1 cycle, then ready with lo=0xFFFFFFFF, hi=0x1234.
- Flush mid-run: flush at RUN cycle 10 → stall_o=0 in that cycle, IDLE next cycle, no ready pulse, hi/lo keep previous values. The next start runs a full 33 cycles.
- Reset mid-run, then back-to-back:
  - rst pulse during RUN → state IDLE, hi=lo=0 immediately.
  - Two consecutive DIVU (20/3 then 9/4) → results lo=6/hi=2 then lo=2/hi=1, with ready pulses 34 cycles apart.
